// File: rtl/cs2fifoc_pkg.sv
// Shared frame definitions for the command-frame link (cs2fifoc / fifoc2cs).
// Header bytes, length limits, state encoding and payload index map.
package cs2fifoc_pkg;

    localparam logic [7:0]  HDR0_B      = 8'h55;
    localparam logic [7:0]  HDR1_B      = 8'hAA;
    localparam logic [11:0] DEF_NUM_LEN = 12'd12;
    localparam logic [11:0] DEF_MAX_LEN = 12'd32;

    localparam int PL_NUM   = 9;
    localparam int PL_FIRST = 2;
    localparam int PL_LAST  = PL_FIRST + PL_NUM - 1;

    typedef enum logic [7:0] {
        S_IDLE = 8'h00,
        S_LOAD = 8'h01,
        S_HDR0 = 8'h02,
        S_HDR1 = 8'h03,
        S_BODY = 8'h04,
        S_CSUM = 8'h05,
        S_LAST = 8'h06
    } state_t;

    // Element 0 is frame byte PL_FIRST (kind_dev), element 8 is cmd_mix1
    typedef logic [PL_NUM-1:0][7:0] payload_t;

    function automatic logic len_ok(
        input logic [11:0] len,
        input logic [11:0] lo,
        input logic [11:0] hi
    );
        return (len >= lo) && (len <= hi);
    endfunction

endpackage

// File: rtl/cs2fifoc_if.sv
// Command FIFO write port: write enable, write data and full flag.
interface cs2fifoc_if;
    logic       fifoc_txen;
    logic [7:0] fifoc_txd;
    logic       fifoc_full;

    modport master (
        output fifoc_txen,
        output fifoc_txd,
        input  fifoc_full
    );

    modport slave (
        input  fifoc_txen,
        input  fifoc_txd,
        output fifoc_full
    );
endinterface

// File: rtl/cs2fifoc_csum_acc.sv
// 8-bit modulo-256 checksum accumulator, shared with the frame receiver.
module cs2fifoc_csum_acc (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] din,
    output logic [7:0] sum
);

    always_ff @(posedge clk) begin
        if (rst || clr)
            sum <= 8'h00;
        else if (en)
            sum <= sum + din;
    end

endmodule

// File: rtl/cs2fifoc.sv
// Command-frame transmitter: 55 AA, 9 payload bytes, zero pad, checksum.
// Define CS2FIFOC_FULL_EN to stall the frame while fifoc_full is high.
module cs2fifoc
    import cs2fifoc_pkg::*;
#(
    parameter logic [11:0] NUM_LEN = DEF_NUM_LEN,
    parameter logic [11:0] MAX_LEN = DEF_MAX_LEN
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fs,
    output logic        fd,
    output logic        err,
    input  logic [11:0] data_len,
    input  logic [7:0]  kind_dev,
    input  logic [7:0]  info_sr,
    input  logic [7:0]  cmd_filt,
    input  logic [7:0]  cmd_mix0,
    input  logic [7:0]  cmd_reg4,
    input  logic [7:0]  cmd_reg5,
    input  logic [7:0]  cmd_reg6,
    input  logic [7:0]  cmd_reg7,
    input  logic [7:0]  cmd_mix1,
    cs2fifoc_if.master  fifo
);

    state_t      state_q, state_d;
    logic [11:0] idx_q;
    logic [11:0] len_q;
    payload_t    pl_q;
    logic        err_q;
    logic        go;
    logic        txen;
    logic [7:0]  txd;
    logic [7:0]  body_b;
    logic [3:0]  pidx;
    logic        sum_clr;
    logic        sum_en;
    logic [7:0]  sum;

`ifdef CS2FIFOC_FULL_EN
    assign go = ~fifo.fifoc_full;
`else
    assign go = 1'b1;
`endif

    assign pidx   = idx_q[3:0] - 4'd2;
    assign body_b = (idx_q <= 12'(PL_LAST)) ? pl_q[pidx] : 8'h00;

    always_comb begin
        state_d = state_q;
        txen    = 1'b0;
        txd     = 8'h00;
        sum_clr = 1'b0;
        sum_en  = 1'b0;
        unique case (state_q)
            S_IDLE: if (fs) state_d = S_LOAD;
            S_LOAD: begin
                sum_clr = 1'b1;
                state_d = len_ok(data_len, NUM_LEN, MAX_LEN)
                        ? S_HDR0 : S_LAST;
            end
            S_HDR0: begin
                txen = 1'b1;
                txd  = HDR0_B;
                if (go) state_d = S_HDR1;
            end
            S_HDR1: begin
                txen = 1'b1;
                txd  = HDR1_B;
                if (go) state_d = S_BODY;
            end
            S_BODY: begin
                txen   = 1'b1;
                txd    = body_b;
                sum_en = go;
                if (go && idx_q == len_q - 12'd2)
                    state_d = S_CSUM;
            end
            S_CSUM: begin
                txen = 1'b1;
                txd  = sum;
                if (go) state_d = S_LAST;
            end
            S_LAST: if (!fs) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            pl_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_LOAD) begin
                pl_q  <= {cmd_mix1, cmd_reg7, cmd_reg6,
                          cmd_reg5, cmd_reg4, cmd_mix0,
                          cmd_filt, info_sr, kind_dev};
                len_q <= data_len;
                err_q <= !len_ok(data_len, NUM_LEN, MAX_LEN);
                idx_q <= '0;
            end else if (state_q == S_HDR1 && go) begin
                idx_q <= 12'(PL_FIRST);
            end else if (state_q == S_BODY && go) begin
                idx_q <= idx_q + 12'd1;
            end
        end
    end

    cs2fifoc_csum_acc u_csum (
        .clk (clk),
        .rst (rst),
        .clr (sum_clr),
        .en  (sum_en),
        .din (body_b),
        .sum (sum)
    );

    assign fifo.fifoc_txen = txen & go;
    assign fifo.fifoc_txd  = txd;
    assign fd              = (state_q == S_LAST);
    assign err             = err_q;

endmodule

// File: tb/tb_cs2fifoc.sv
// Directed bench for cs2fifoc: vector table plus stall, abort and reset cases.
module tb_cs2fifoc;

    logic        clk = 1'b0;
    logic        rst;
    logic        fs;
    logic        fd;
    logic        err;
    logic [11:0] data_len;
    logic [7:0]  kind_dev, info_sr, cmd_filt, cmd_mix0, cmd_reg4;
    logic [7:0]  cmd_reg5, cmd_reg6, cmd_reg7, cmd_mix1;

    cs2fifoc_if fifo();

    cs2fifoc dut (
        .clk      (clk),
        .rst      (rst),
        .fs       (fs),
        .fd       (fd),
        .err      (err),
        .data_len (data_len),
        .kind_dev (kind_dev),
        .info_sr  (info_sr),
        .cmd_filt (cmd_filt),
        .cmd_mix0 (cmd_mix0),
        .cmd_reg4 (cmd_reg4),
        .cmd_reg5 (cmd_reg5),
        .cmd_reg6 (cmd_reg6),
        .cmd_reg7 (cmd_reg7),
        .cmd_mix1 (cmd_mix1),
        .fifo     (fifo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0]     len;
        logic [8:0][7:0] f;
        int              n;
        logic [7:0]      cs;
        logic            er;
    } vec_t;

    vec_t vt[9];

    int         tests = 0;
    int         fails = 0;
    int         nw, first_c, last_c;
    bit         saw_fd, aborted;
    logic       err_s;
    logic [7:0] cap[64];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [8:0][7:0] seqf(input logic [7:0] s,
                                            input logic [7:0] st);
        logic [8:0][7:0] r;
        for (int i = 0; i < 9; i++) r[i] = s + 8'(i) * st;
        return r;
    endfunction

    function automatic logic [7:0] expb(input vec_t v, input int i);
        if (i == 0) return 8'h55;
        if (i == 1) return 8'hAA;
        if (i == v.n - 1) return v.cs;
        if (i <= 10) return v.f[i-2];
        return 8'h00;
    endfunction

    task automatic set_fields(input logic [8:0][7:0] f);
        kind_dev = f[0]; info_sr  = f[1]; cmd_filt = f[2];
        cmd_mix0 = f[3]; cmd_reg4 = f[4]; cmd_reg5 = f[5];
        cmd_reg6 = f[6]; cmd_reg7 = f[7]; cmd_mix1 = f[8];
    endtask

    // Called at a negedge with the DUT idle
    task automatic send(input vec_t v, input int drop_at,
                        input int full_at, input int rst_at);
        int  fcnt;
        bit  fdone;
        fcnt = 0; fdone = 0;
        nw = 0; first_c = -1; last_c = -1;
        saw_fd = 0; aborted = 0; err_s = 1'bx;
        set_fields(v.f);
        data_len = v.len;
        fs = 1'b1;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (fcnt > 0) begin
                fcnt--;
                if (fcnt == 0) fifo.fifoc_full = 1'b0;
            end else if (!fdone && full_at >= 0 && nw == full_at) begin
                fifo.fifoc_full = 1'b1;
                fcnt = 3;
                fdone = 1;
            end
            #1;
            if (fifo.fifoc_txen) begin
                if (nw < 64) cap[nw] = fifo.fifoc_txd;
                if (first_c < 0) first_c = c;
                last_c = c;
                nw++;
                if (nw == drop_at) begin
                    fs = 1'b0;
                    set_fields(seqf(8'hEE, 8'h00));
                    data_len = 12'd0;
                end
                if (nw == rst_at) begin
                    rst = 1'b1;
                    @(negedge clk); #1;
                    chk("rst_txen", fifo.fifoc_txen, 0);
                    chk("rst_fd", fd, 0);
                    rst = 1'b0;
                    aborted = 1;
                    break;
                end
            end
            if (fd) begin
                saw_fd = 1;
                err_s = err;
                break;
            end
        end
        fs = 1'b0;
        fifo.fifoc_full = 1'b0;
        if (!aborted) begin
            @(negedge clk); #1;
            chk("fd_drop", fd, 0);
        end
    endtask

    task automatic check(input vec_t v, input int span);
        chk("writes", nw, v.n);
        chk("fd_seen", saw_fd, 1);
        chk("err", err_s, v.er);
        if (v.n > 0) begin
            chk("latency", first_c, 2);
            if (span > 0) chk("span", last_c - first_c + 1, span);
            for (int i = 0; i < v.n && i < nw && i < 64; i++)
                chk($sformatf("byte%0d", i), cap[i], expb(v, i));
        end
    endtask

    initial begin
        vt[0] = '{12'd12, seqf(8'h01, 8'h01), 12, 8'h2D, 1'b0};
        vt[1] = '{12'd14, seqf(8'h01, 8'h01), 14, 8'h2D, 1'b0};
        vt[2] = '{12'd11, seqf(8'h01, 8'h01), 0, 8'h00, 1'b1};
        vt[3] = '{12'd33, seqf(8'h01, 8'h01), 0, 8'h00, 1'b1};
        vt[4] = '{12'd12, seqf(8'h01, 8'h01), 12, 8'h2D, 1'b0};
        vt[5] = '{12'd32, '0, 32, 8'hEE, 1'b0};
        vt[5].f = {8'h50, 8'h40, 8'h30, 8'h20, 8'h10,
                   8'h00, 8'h7F, 8'h80, 8'hFF};
        vt[6] = '{12'd13, seqf(8'h10, 8'h10), 13, 8'hD0, 1'b0};
        vt[7] = '{12'd0, seqf(8'h01, 8'h01), 0, 8'h00, 1'b1};
        vt[8] = '{12'd4095, seqf(8'h01, 8'h01), 0, 8'h00, 1'b1};

        rst = 1'b1; fs = 1'b0; data_len = '0;
        fifo.fifoc_full = 1'b0;
        set_fields('0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_txen", fifo.fifoc_txen, 0);
        chk("rst_txd", fifo.fifoc_txd, 0);
        chk("rst_fd", fd, 0);
        chk("rst_err", err, 0);

        for (int k = 0; k < 9; k++) begin
            send(vt[k], -1, -1, -1);
            check(vt[k], vt[k].n);
            chk("err_hold", err, vt[k].er);
        end

        // fs released and fields scrambled mid-frame
        send(vt[1], 3, -1, -1);
        check(vt[1], 14);

        // FIFO full for three cycles while byte 5 is pending
        send(vt[0], -1, 5, -1);
`ifdef CS2FIFOC_FULL_EN
        check(vt[0], 15);
`else
        check(vt[0], 12);
`endif

        // reset at the 6th write, then a clean frame
        send(vt[0], -1, -1, 6);
        chk("rst_abort", aborted, 1);
        chk("rst_nw", nw, 6);
        @(negedge clk);
        send(vt[0], -1, -1, -1);
        check(vt[0], 12);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
